matrix_to_sevenseg: RTL and testbench

Receiver/decoder for the strobed 4x8 LED-matrix seven-segment display bus, which carries active-low one-hot column strobes and active-low row data. The block samples the bus, captures one 8-bit row word per column over a full 0→1→2→3 scan, and reconstructs the active-low seven-segment byte. It sits on the far end of the matrix bus, for loopback self-test and for board-level monitoring of the display driver.

---
 rtl/matrix_to_sevenseg.sv | 226 ++++++++++++++++++++++
 tb/tb_matrix_to_sevenseg.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/matrix_to_sevenseg.sv
// Receiver for the strobed 4x8 LED-matrix seven-segment bus: captures one row
// word per column over a 0..3 scan and rebuilds the active-low segment byte.
module matrix_to_sevenseg #(
    parameter int SETTLE    = 4,
    parameter int TIMEOUT_W = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] io_col,
    input  logic [7:0] io_out,
    output logic [7:0] sevenseg_out,
    output logic       frame_valid,
    output logic       frame_err,
    output logic       seq_err
);

    typedef enum logic [1:0] {HUNT = 2'd0, CAP1 = 2'd1, CAP2 = 2'd2, CAP3 = 2'd3} state_t;

    localparam logic [3:0] SETTLE_C  = 4'(SETTLE);
    localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);
    // Mapped pixels: outer columns use rows 1,2,4,5; inner columns rows 0,3,6.
    localparam logic [7:0] MASK_OUTER = 8'h36;
    localparam logic [7:0] MASK_INNER = 8'h49;

    logic [3:0]           col_s1, col_s2;
    logic [7:0]           row_s1, row_s2;
    logic [11:0]          cur_word, prev_word, last_word;
    logic [3:0]           stab_cnt;
    logic                 word_stable, settle_hit;
    logic [3:0]           col;
    logic [7:0]           row;
    logic                 col_onehot;
    logic [1:0]           col_idx;
    logic [TIMEOUT_W-1:0] dwell_cnt;
    logic                 timeout;

    state_t               state, state_next;
    logic [2:0]           cap_we;
    logic                 publish, abort;
    logic [7:0]           cap [3];

    logic [7:0]           frame [4];
    logic [6:0]           pix_x, pix_y, seg_on, seg_half;
    logic                 stray;
    logic [7:0]           decoded;
    logic                 decode_err;

    // Synchronizers idle at the inactive (all-ones) bus level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_s1 <= '1;
            col_s2 <= '1;
            row_s1 <= '1;
            row_s2 <= '1;
        end else begin
            // NOTE: non-blocking assignments make col_s2 take the old col_s1, forming a real two-stage chain.
            col_s1 <= io_col;
            col_s2 <= col_s1;
            row_s1 <= io_out;
            row_s2 <= row_s1;
        end
    end

    assign cur_word    = {~col_s2, ~row_s2};
    assign col         = cur_word[11:8];
    assign row         = cur_word[7:0];
    assign word_stable = (cur_word == prev_word);

    // last_word suppresses a second acceptance when the bus settles back after a glitch.
    assign settle_hit  = word_stable && (stab_cnt == SETTLE_M1) && (cur_word != last_word);

    assign col_onehot  = (col != 4'd0) && ((col & (col - 4'd1)) == 4'd0);

    always_comb begin
        col_idx = 2'd0;
        unique case (col)
            4'b0010: col_idx = 2'd1;
            4'b0100: col_idx = 2'd2;
            4'b1000: col_idx = 2'd3;
            default: col_idx = 2'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_word <= '0;
            last_word <= '0;
            stab_cnt  <= '0;
        end else begin
            prev_word <= cur_word;
            if (!word_stable)
                stab_cnt <= '0;
            else if (stab_cnt != SETTLE_C)
                stab_cnt <= stab_cnt + 4'd1;
            if (settle_hit)
                last_word <= cur_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            dwell_cnt <= '0;
        else if (settle_hit)
            dwell_cnt <= '0;
        else
            dwell_cnt <= dwell_cnt + 1'b1;
    end

    assign timeout = (&dwell_cnt) && (state != HUNT) && !settle_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= HUNT;
        else
            state <= state_next;
    end

    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        state_next = state;
        cap_we     = 3'b000;
        publish    = 1'b0;
        abort      = 1'b0;
        if (settle_hit) begin
            if (!col_onehot) begin
                abort      = 1'b1;
                state_next = HUNT;
            end else begin
                unique case (state)
                    HUNT: begin
                        if (col_idx == 2'd0) begin
                            cap_we[0]  = 1'b1;
                            state_next = CAP1;
                        end
                    end
                    CAP1: begin
                        if (col_idx == 2'd1) begin
                            cap_we[1]  = 1'b1;
                            state_next = CAP2;
                        end else begin
                            abort = 1'b1;
                        end
                    end
                    CAP2: begin
                        if (col_idx == 2'd2) begin
                            cap_we[2]  = 1'b1;
                            state_next = CAP3;
                        end else begin
                            abort = 1'b1;
                        end
                    end
                    CAP3: begin
                        if (col_idx == 2'd3) begin
                            publish    = 1'b1;
                            state_next = HUNT;
                        end else begin
                            abort = 1'b1;
                        end
                    end
                    default: state_next = HUNT;
                endcase
                // An out-of-order col0 restarts the frame rather than dropping it.
                if (abort) begin
                    if (col_idx == 2'd0) begin
                        cap_we[0]  = 1'b1;
                        state_next = CAP1;
                    end else begin
                        state_next = HUNT;
                    end
                end
            end
        end else if (timeout) begin
            abort      = 1'b1;
            state_next = HUNT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the capture words are cleared on reset; they are only 24 flops, not a RAM.
            for (int i = 0; i < 3; i++) cap[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++)
                if (cap_we[i]) cap[i] <= row;
        end
    end

    // Column 3 is decoded straight from the bus word on the cycle it is accepted.
    always_comb begin
        frame[0] = cap[0];
        frame[1] = cap[1];
        frame[2] = cap[2];
        frame[3] = row;
    end

    // Segment bit order g..a; each segment is the AND of two pixels.
    always_comb begin
        pix_x = {frame[1][3], frame[0][1], frame[0][4], frame[1][6],
                 frame[3][4], frame[3][1], frame[1][0]};
        pix_y = {frame[2][3], frame[0][2], frame[0][5], frame[2][6],
                 frame[3][5], frame[3][2], frame[2][0]};
        seg_on   = pix_x & pix_y;
        seg_half = pix_x ^ pix_y;
        stray    = (|(frame[0] & ~MASK_OUTER)) | (|(frame[1] & ~MASK_INNER)) |
                   (|(frame[2] & ~MASK_INNER)) | (|(frame[3] & ~MASK_OUTER));
        decoded    = {1'b1, ~seg_on};
        decode_err = (|seg_half) | stray;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sevenseg_out <= 8'hFF;
            frame_err    <= 1'b0;
            frame_valid  <= 1'b0;
            seq_err      <= 1'b0;
        end else begin
            frame_valid <= publish;
            seq_err     <= abort;
            if (publish) begin
                sevenseg_out <= decoded;
                frame_err    <= decode_err;
            end
        end
    end

endmodule

// File: tb/tb_matrix_to_sevenseg.sv
// Scoreboard bench for matrix_to_sevenseg: directed column scans push expected
// publish/abort events; a negedge monitor pops and compares them.
module tb_matrix_to_sevenseg;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] io_col;
    logic [7:0] io_out;
    logic [7:0] sevenseg_out;
    logic       frame_valid;
    logic       frame_err;
    logic       seq_err;

    typedef struct {
        bit         is_seq;
        logic [7:0] seg;
        logic       err;
    } exp_t;

    exp_t       sb_q[$];
    int         total = 0;
    int         bad   = 0;
    logic [7:0] hold_seg = 8'hFF;
    logic       hold_err = 1'b0;

    // Active-high row words per column for the digits used here.
    localparam logic [7:0] OUTER = 8'h36;
    localparam logic [7:0] INNER = 8'h49;

    matrix_to_sevenseg #(.SETTLE(4), .TIMEOUT_W(6)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .io_col       (io_col),
        .io_out       (io_out),
        .sevenseg_out (sevenseg_out),
        .frame_valid  (frame_valid),
        .frame_err    (frame_err),
        .seq_err      (seq_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_pub(input logic [7:0] seg, input logic err);
        exp_t e;
        e.is_seq = 1'b0;
        e.seg    = seg;
        e.err    = err;
        sb_q.push_back(e);
        hold_seg = seg;
        hold_err = err;
    endtask

    task automatic expect_seq();
        exp_t e;
        e.is_seq = 1'b1;
        e.seg    = hold_seg;
        e.err    = hold_err;
        sb_q.push_back(e);
    endtask

    task automatic dwell_raw(input logic [3:0] col_n, input logic [7:0] rows_act, input int n);
        io_col = col_n;
        io_out = ~rows_act;
        repeat (n) @(negedge clk);
    endtask

    task automatic dwell(input int c, input logic [7:0] rows_act, input int n);
        logic [3:0] one;
        one = 4'b0001;
        dwell_raw(~(one << c), rows_act, n);
    endtask

    task automatic scan(input logic [7:0] r0, input logic [7:0] r1,
                        input logic [7:0] r2, input logic [7:0] r3);
        dwell(0, r0, 20);
        dwell(1, r1, 20);
        dwell(2, r2, 20);
        dwell(3, r3, 20);
    endtask

    // Monitor: every DUT event must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && (frame_valid || seq_err)) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_event: got fv=%0b se=%0b seg=%0h expected none",
                         frame_valid, seq_err, sevenseg_out);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check(e.is_seq ? "seq_kind" : "pub_kind", {30'd0, frame_valid, seq_err},
                      e.is_seq ? 32'd1 : 32'd2);
                check(e.is_seq ? "seq_seg_hold" : "pub_seg", {24'd0, sevenseg_out}, {24'd0, e.seg});
                check(e.is_seq ? "seq_err_hold" : "pub_err", {31'd0, frame_err}, {31'd0, e.err});
            end
        end
    end

    initial begin
        io_col = 4'b0111;
        io_out = 8'hFF;
        rst_n  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_seg", {24'd0, sevenseg_out}, 32'hFF);
        check("rst_fv",  {31'd0, frame_valid}, 32'd0);
        check("rst_fe",  {31'd0, frame_err}, 32'd0);
        check("rst_se",  {31'd0, seq_err}, 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Digit 8: all segments.
        expect_pub(8'h80, 1'b0);
        scan(OUTER, INNER, INNER, OUTER);

        // Digit 1, then digit 1 with row 4 missing (segment c half lit).
        expect_pub(8'hF9, 1'b0);
        scan(8'h00, 8'h00, 8'h00, OUTER);
        expect_pub(8'hFD, 1'b1);
        scan(8'h00, 8'h00, 8'h00, 8'h26);

        // Skipped column: col0 then col2.
        expect_seq();
        dwell(0, OUTER, 20);
        dwell(2, INNER, 20);
        expect_pub(8'h80, 1'b0);
        scan(OUTER, INNER, INNER, OUTER);

        // Multi-hot strobe mid-frame.
        expect_seq();
        dwell(0, OUTER, 20);
        dwell(1, INNER, 20);
        dwell_raw(4'b1100, 8'h00, 10);
        expect_pub(8'hF9, 1'b0);
        scan(8'h00, 8'h00, 8'h00, OUTER);

        // Short glitch to col3 inside the col1 dwell.
        expect_pub(8'h80, 1'b0);
        dwell(0, OUTER, 20);
        dwell(1, INNER, 10);
        dwell(3, OUTER, 2);
        dwell(1, INNER, 8);
        dwell(2, INNER, 20);
        dwell(3, OUTER, 20);

        // Dwell timeout on col1 (2^6 cycles), trailing columns ignored in HUNT.
        expect_seq();
        dwell(0, OUTER, 20);
        dwell(1, INNER, 100);
        dwell(2, INNER, 20);
        dwell(3, OUTER, 20);
        expect_pub(8'hFD, 1'b1);
        scan(8'h00, 8'h00, 8'h00, 8'h26);

        // Asynchronous reset mid-frame.
        dwell(0, OUTER, 20);
        dwell(1, INNER, 10);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_seg", {24'd0, sevenseg_out}, 32'hFF);
        check("arst_fe",  {31'd0, frame_err}, 32'd0);
        check("arst_fv",  {31'd0, frame_valid}, 32'd0);
        hold_seg = 8'hFF;
        hold_err = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        dwell(1, INNER, 10);
        dwell(2, INNER, 20);
        dwell(3, OUTER, 20);
        expect_pub(8'h80, 1'b0);
        scan(OUTER, INNER, INNER, OUTER);

        for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(negedge clk);
        check("drain_pending", sb_q.size(), 32'd0);
        repeat (20) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
